// File: rtl/spart_pkg.sv
// Shared SPART register map, status field layout and host FSM types.
// Used by spart_host_if, its stream interface and the bench.
package spart_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_DBUF = 2'b00;
    localparam logic [ADDR_W-1:0] ADDR_SREG = 2'b01;
    localparam logic [ADDR_W-1:0] ADDR_DBL  = 2'b10;
    localparam logic [ADDR_W-1:0] ADDR_DBH  = 2'b11;

    // SREG = {tx_free, rx_cnt}
    localparam int unsigned SREG_TXFREE_HI = 7;
    localparam int unsigned SREG_TXFREE_LO = 4;
    localparam int unsigned SREG_RXCNT_HI  = 3;
    localparam int unsigned SREG_RXCNT_LO  = 0;

    typedef enum logic [2:0] {
        ST_INIT_DBL,
        ST_INIT_DBH,
        ST_POLL,
        ST_DECIDE,
        ST_WR_TX,
        ST_RD_RX
    } host_state_t;

    typedef struct packed {
        logic              cs_n;
        logic              rw_n;
        logic [ADDR_W-1:0] addr;
        logic              drive;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    function automatic bus_req_t bus_idle();
        bus_req_t r;
        r.cs_n  = 1'b1;
        r.rw_n  = 1'b1;
        r.addr  = ADDR_DBUF;
        r.drive = 1'b0;
        r.wdata = '0;
        return r;
    endfunction

    function automatic bus_req_t write_req(logic [ADDR_W-1:0] addr, logic [DATA_W-1:0] data);
        bus_req_t r;
        r.cs_n  = 1'b0;
        r.rw_n  = 1'b0;
        r.addr  = addr;
        r.drive = 1'b1;
        r.wdata = data;
        return r;
    endfunction

    function automatic bus_req_t read_req(logic [ADDR_W-1:0] addr);
        bus_req_t r;
        r.cs_n  = 1'b0;
        r.rw_n  = 1'b1;
        r.addr  = addr;
        r.drive = 1'b0;
        r.wdata = '0;
        return r;
    endfunction

endpackage

// File: rtl/spart_host_if_if.sv
// Valid/ready byte stream between the datapath (master) and spart_host_if (slave).
interface spart_host_if_if;
    import spart_pkg::*;

    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );

endinterface

// File: rtl/spart_host_if.sv
// SPART register-bus initiator: programs the baud divisor, then polls SREG and
// moves bytes between a valid/ready stream and DBUF, round-robin between TX and RX.
module spart_host_if
    import spart_pkg::*;
#(
    parameter logic [15:0] BAUD_DIV    = 16'h0A2C,
    parameter int unsigned QUEUE_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    spart_host_if_if.slave    strm,
    output logic              init_done,
    output logic              iocs_n,
    output logic              iorw_n,
    output logic [ADDR_W-1:0] ioaddr,
    inout  wire  [DATA_W-1:0] databus
);

    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

    host_state_t       state_q, state_d;
    logic              run_q, run_d;
    logic [CNT_W-1:0]  tx_free_q, tx_free_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic              last_rx_q, last_rx_d;
    logic              init_done_q, init_done_d;
    logic              tx_ready_q, tx_ready_d;
    logic [DATA_W-1:0] tx_hold_q, tx_hold_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    bus_req_t          bus_q, bus_d;
    logic              rx_ok, tx_ok;

    // Next state, holding registers and the registered bus request for the next cycle
    always_comb begin
        state_d     = state_q;
        run_d       = 1'b1;
        tx_free_d   = tx_free_q;
        rx_cnt_d    = rx_cnt_q;
        last_rx_d   = last_rx_q;
        init_done_d = init_done_q;
        tx_ready_d  = tx_ready_q;
        tx_hold_d   = tx_hold_q;
        rx_valid_d  = rx_valid_q;
        rx_data_d   = rx_data_q;
        bus_d       = bus_idle();

        rx_ok = (rx_cnt_q != '0) && !rx_valid_q;
        tx_ok = (tx_free_q != '0) && !tx_ready_q;

        if (strm.tx_valid && tx_ready_q) begin
            tx_hold_d  = strm.tx_data;
            tx_ready_d = 1'b0;
        end
        if (rx_valid_q && strm.rx_ready) begin
            rx_valid_d = 1'b0;
        end

        // First cycle out of reset only launches the DBL write
        if (run_q) begin
            unique case (state_q)
                ST_INIT_DBL: state_d = ST_INIT_DBH;
                ST_INIT_DBH: begin
                    init_done_d = 1'b1;
                    state_d     = ST_POLL;
                end
                ST_POLL: begin
                    tx_free_d = CNT_W'(databus[SREG_TXFREE_HI:SREG_TXFREE_LO]);
                    rx_cnt_d  = CNT_W'(databus[SREG_RXCNT_HI:SREG_RXCNT_LO]);
                    state_d   = ST_DECIDE;
                end
                ST_DECIDE: begin
                    if (rx_ok && tx_ok) state_d = last_rx_q ? ST_WR_TX : ST_RD_RX;
                    else if (rx_ok)     state_d = ST_RD_RX;
                    else if (tx_ok)     state_d = ST_WR_TX;
                    else                state_d = ST_POLL;
                end
                ST_WR_TX: begin
                    tx_ready_d = 1'b1;
                    last_rx_d  = 1'b0;
                    state_d    = ST_POLL;
                end
                ST_RD_RX: begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = databus;
                    last_rx_d  = 1'b1;
                    state_d    = ST_POLL;
                end
                default: state_d = ST_INIT_DBL;
            endcase
        end

        unique case (state_d)
            ST_INIT_DBL: bus_d = write_req(ADDR_DBL, BAUD_DIV[7:0]);
            ST_INIT_DBH: bus_d = write_req(ADDR_DBH, BAUD_DIV[15:8]);
            ST_POLL:     bus_d = read_req(ADDR_SREG);
            ST_WR_TX:    bus_d = write_req(ADDR_DBUF, tx_hold_q);
            ST_RD_RX:    bus_d = read_req(ADDR_DBUF);
            default:     bus_d = bus_idle();
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_INIT_DBL;
            run_q       <= 1'b0;
            tx_free_q   <= '0;
            rx_cnt_q    <= '0;
            last_rx_q   <= 1'b0;
            init_done_q <= 1'b0;
            tx_ready_q  <= 1'b1;
            tx_hold_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            bus_q       <= bus_idle();
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            tx_free_q   <= tx_free_d;
            rx_cnt_q    <= rx_cnt_d;
            last_rx_q   <= last_rx_d;
            init_done_q <= init_done_d;
            tx_ready_q  <= tx_ready_d;
            tx_hold_q   <= tx_hold_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            bus_q       <= bus_d;
        end
    end

    assign iocs_n        = bus_q.cs_n;
    assign iorw_n        = bus_q.rw_n;
    assign ioaddr        = bus_q.addr;
    assign databus       = bus_q.drive ? bus_q.wdata : {DATA_W{1'bz}};
    assign init_done     = init_done_q;
    assign strm.tx_ready = tx_ready_q;
    assign strm.rx_valid = rx_valid_q;
    assign strm.rx_data  = rx_data_q;

endmodule

// File: tb/tb_spart_host_if.sv
// Directed bench for spart_host_if against a behavioural SPART register model
// (8-deep TX/RX queues, SREG = {tx_free, rx_cnt}, TX drained at a set rate).
module tb_spart_host_if;
    import spart_pkg::*;

    typedef struct packed {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] data;
    } acc_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iocs_n, iorw_n, init_done;
    logic [1:0] ioaddr;
    wire  [7:0] databus;

    spart_host_if_if sif();

    spart_host_if #(.BAUD_DIV(16'h0A2C), .QUEUE_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .strm(sif), .init_done(init_done),
        .iocs_n(iocs_n), .iorw_n(iorw_n), .ioaddr(ioaddr), .databus(databus)
    );

    initial forever #10 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // SPART model state
    logic [7:0] txq[$], rxq[$], uart_got[$], rx_got[$];
    acc_t       acc_log[$];
    logic       dbuf_seq[$];
    logic [7:0] rd_q = 8'h00;
    logic [7:0] prev_sreg = 8'h00;
    logic       prev_sreg_vld = 1'b0;
    int tx_period = 40, tx_cnt = 0;
    int viol_tx = 0, viol_rx = 0, ovf = 0, unf = 0;
    int max_tx_lvl = 0, max_rxcnt = 0, dbuf_reads = 0;
    bit sreg_full_seen = 1'b0;

    assign databus = (iocs_n == 1'b0 && iorw_n == 1'b1) ? rd_q : 8'bzzzz_zzzz;

    // Register model, TX drain and stream consumer, all mid-cycle
    initial forever begin
        logic [7:0] v;
        @(negedge clk);
        if (iocs_n == 1'b0) begin
            if (iorw_n == 1'b0) begin
                acc_log.push_back('{wr: 1'b1, addr: ioaddr, data: databus});
                if (ioaddr == ADDR_DBUF) begin
                    dbuf_seq.push_back(1'b1);
                    if (!(prev_sreg_vld && prev_sreg[7:4] != 4'd0)) viol_tx++;
                    if (txq.size() >= 8) ovf++;
                    else txq.push_back(databus);
                end
                prev_sreg_vld = 1'b0;
            end else begin
                v = 8'h00;
                if (ioaddr == ADDR_SREG) begin
                    v = {4'(8 - txq.size()), 4'(rxq.size())};
                    if (v[7:4] == 4'd0) sreg_full_seen = 1'b1;
                    if (int'(v[3:0]) > max_rxcnt) max_rxcnt = int'(v[3:0]);
                end else if (ioaddr == ADDR_DBUF) begin
                    dbuf_seq.push_back(1'b0);
                    dbuf_reads++;
                    if (!(prev_sreg_vld && prev_sreg[3:0] != 4'd0)) viol_rx++;
                    if (rxq.size() == 0) unf++;
                    else v = rxq.pop_front();
                end
                rd_q = v;
                acc_log.push_back('{wr: 1'b0, addr: ioaddr, data: v});
                prev_sreg_vld = (ioaddr == ADDR_SREG);
                prev_sreg = v;
            end
        end
        if (txq.size() > max_tx_lvl) max_tx_lvl = txq.size();
        if (txq.size() > 0) begin
            tx_cnt++;
            if (tx_cnt >= tx_period) begin
                uart_got.push_back(txq.pop_front());
                tx_cnt = 0;
            end
        end
        if (sif.rx_valid && sif.rx_ready) rx_got.push_back(sif.rx_data);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        sif.tx_data  = b;
        sif.tx_valid = 1'b1;
        for (int i = 0; i < 500 && !ok; i++) begin
            ok = sif.tx_ready;
            step();
        end
        sif.tx_valid = 1'b0;
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL send_byte timeout: byte %h never accepted", b);
        end
    endtask

    task automatic test_reset();
        int t;
        repeat (3) step();
        n_cmp++; if (iocs_n !== 1'b1) begin n_fail++; $display("FAIL rst_iocs_n: got %b want 1", iocs_n); end
        n_cmp++; if (iorw_n !== 1'b1) begin n_fail++; $display("FAIL rst_iorw_n: got %b want 1", iorw_n); end
        n_cmp++; if (ioaddr !== 2'b00) begin n_fail++; $display("FAIL rst_ioaddr: got %b want 00", ioaddr); end
        n_cmp++; if (sif.tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_tx_ready: got %b want 1", sif.tx_ready); end
        n_cmp++; if (sif.rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rx_valid: got %b want 0", sif.rx_valid); end
        n_cmp++; if (sif.rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_rx_data: got %h want 00", sif.rx_data); end
        n_cmp++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL rst_init_done: got %b want 0", init_done); end
        rst_n = 1'b1;
        t = 0;
        while (init_done !== 1'b1 && t < 50) begin step(); t++; end
        n_cmp++;
        if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_done timeout: got %b want 1", init_done); end
        n_cmp++;
        if (acc_log.size() != 2) begin n_fail++; $display("FAIL init_done_timing: %0d accesses before init_done, want 2", acc_log.size()); end
        t = 0;
        while (acc_log.size() < 3 && t < 50) begin step(); t++; end
        n_cmp++;
        if (acc_log.size() < 3) begin n_fail++; $display("FAIL boot_access timeout: %0d accesses want 3", acc_log.size()); end
        else begin
            n_cmp++; if (acc_log[0] !== '{wr: 1'b1, addr: ADDR_DBL, data: 8'h2C}) begin n_fail++; $display("FAIL boot_dbl: got %h want %h", acc_log[0], acc_t'({1'b1, ADDR_DBL, 8'h2C})); end
            n_cmp++; if (acc_log[1] !== '{wr: 1'b1, addr: ADDR_DBH, data: 8'h0A}) begin n_fail++; $display("FAIL boot_dbh: got %h want %h", acc_log[1], acc_t'({1'b1, ADDR_DBH, 8'h0A})); end
            n_cmp++; if (acc_log[2] !== '{wr: 1'b0, addr: ADDR_SREG, data: 8'h80}) begin n_fail++; $display("FAIL boot_sreg: got %h want %h", acc_log[2], acc_t'({1'b0, ADDR_SREG, 8'h80})); end
        end
    endtask

    task automatic test_tx_burst();
        int t = 0;
        uart_got.delete();
        for (int i = 0; i < 9; i++) send_byte(8'(8'h11 * (i + 1)));
        while (uart_got.size() < 9 && t < 2000) begin step(); t++; end
        n_cmp++;
        if (uart_got.size() != 9) begin n_fail++; $display("FAIL tx_count: got %0d want 9", uart_got.size()); end
        else for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if (uart_got[i] !== 8'(8'h11 * (i + 1))) begin n_fail++; $display("FAIL tx_byte%0d: got %h want %h", i, uart_got[i], 8'(8'h11 * (i + 1))); end
        end
        n_cmp++; if (viol_tx != 0) begin n_fail++; $display("FAIL tx_unpolled_write: got %0d want 0", viol_tx); end
        n_cmp++; if (ovf != 0) begin n_fail++; $display("FAIL tx_overflow: got %0d want 0", ovf); end
        n_cmp++; if (max_tx_lvl != 8) begin n_fail++; $display("FAIL tx_fill_level: got %0d want 8", max_tx_lvl); end
        n_cmp++; if (sreg_full_seen !== 1'b1) begin n_fail++; $display("FAIL tx_full_polled: got %b want 1", sreg_full_seen); end
    endtask

    task automatic test_rx_basic();
        logic [7:0] exp [3];
        int t = 0;
        exp[0] = 8'hA5; exp[1] = 8'h3C; exp[2] = 8'hFF;
        rx_got.delete();
        sif.rx_ready = 1'b1;
        for (int i = 0; i < 3; i++) rxq.push_back(exp[i]);
        while (rx_got.size() < 3 && t < 500) begin step(); t++; end
        n_cmp++;
        if (rx_got.size() != 3) begin n_fail++; $display("FAIL rx_count: got %0d want 3", rx_got.size()); end
        else for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rx_got[i] !== exp[i]) begin n_fail++; $display("FAIL rx_byte%0d: got %h want %h", i, rx_got[i], exp[i]); end
        end
        n_cmp++; if (viol_rx != 0 || unf != 0) begin n_fail++; $display("FAIL rx_unpolled_read: got %0d/%0d want 0/0", viol_rx, unf); end
    endtask

    task automatic test_rx_backpressure();
        int reads0, t;
        rx_got.delete();
        max_rxcnt = 0;
        sif.rx_ready = 1'b0;
        reads0 = dbuf_reads;
        // byte 0 lands in rx_data, the next 8 fill the SPART queue
        for (int i = 0; i < 9; i++) begin
            t = 0;
            while (rxq.size() >= 8 && t < 100) begin step(); t++; end
            rxq.push_back(8'(8'h60 + i));
            repeat (3) step();
        end
        repeat (60) step();
        n_cmp++; if (sif.rx_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rx_valid: got %b want 1", sif.rx_valid); end
        n_cmp++; if (sif.rx_data !== 8'h60) begin n_fail++; $display("FAIL bp_rx_data: got %h want 60", sif.rx_data); end
        n_cmp++; if (dbuf_reads - reads0 != 1) begin n_fail++; $display("FAIL bp_reads: got %0d want 1", dbuf_reads - reads0); end
        n_cmp++; if (max_rxcnt != 8) begin n_fail++; $display("FAIL bp_rxcnt: got %0d want 8", max_rxcnt); end
        sif.rx_ready = 1'b1;
        t = 0;
        while (rx_got.size() < 9 && t < 1000) begin step(); t++; end
        n_cmp++;
        if (rx_got.size() != 9) begin n_fail++; $display("FAIL bp_drain_count: got %0d want 9", rx_got.size()); end
        else for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if (rx_got[i] !== 8'(8'h60 + i)) begin n_fail++; $display("FAIL bp_byte%0d: got %h want %h", i, rx_got[i], 8'(8'h60 + i)); end
        end
    endtask

    task automatic test_round_robin();
        int t = 0, nw = 0, nr = 0, same = 0, bad_tx = 0, bad_rx = 0;
        uart_got.delete();
        rx_got.delete();
        dbuf_seq.delete();
        tx_period = 2;
        sif.rx_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i));
            end
            begin
                for (int i = 0; i < 16; i++) begin
                    int w = 0;
                    while (rxq.size() >= 8 && w < 200) begin step(); w++; end
                    rxq.push_back(8'(8'hC0 + i));
                    step();
                end
            end
        join
        while ((uart_got.size() < 16 || rx_got.size() < 16) && t < 2000) begin step(); t++; end
        foreach (dbuf_seq[i]) if (dbuf_seq[i]) nw++; else nr++;
        for (int i = 1; i < 28 && i < dbuf_seq.size(); i++) if (dbuf_seq[i] == dbuf_seq[i-1]) same++;
        for (int i = 0; i < 16 && i < uart_got.size(); i++) if (uart_got[i] !== 8'(8'h40 + i)) bad_tx++;
        for (int i = 0; i < 16 && i < rx_got.size(); i++) if (rx_got[i] !== 8'(8'hC0 + i)) bad_rx++;
        n_cmp++; if (nw != 16) begin n_fail++; $display("FAIL rr_writes: got %0d want 16", nw); end
        n_cmp++; if (nr != 16) begin n_fail++; $display("FAIL rr_reads: got %0d want 16", nr); end
        n_cmp++; if (same != 0) begin n_fail++; $display("FAIL rr_alternation: %0d repeated directions want 0", same); end
        n_cmp++; if (uart_got.size() != 16 || bad_tx != 0) begin n_fail++; $display("FAIL rr_tx_data: got %0d bytes %0d wrong want 16/0", uart_got.size(), bad_tx); end
        n_cmp++; if (rx_got.size() != 16 || bad_rx != 0) begin n_fail++; $display("FAIL rr_rx_data: got %0d bytes %0d wrong want 16/0", rx_got.size(), bad_rx); end
        tx_period = 40;
    endtask

    task automatic test_reset_mid_write();
        int t = 0, idx;
        bit hit = 1'b0;
        sif.rx_ready = 1'b0;
        rxq.push_back(8'h5A);
        while (sif.rx_valid !== 1'b1 && t < 200) begin step(); t++; end
        n_cmp++; if (sif.rx_valid !== 1'b1) begin n_fail++; $display("FAIL mid_rx_setup: got %b want 1", sif.rx_valid); end
        sif.tx_data  = 8'h77;
        sif.tx_valid = 1'b1;
        t = 0;
        while (!hit && t < 200) begin
            step(); t++;
            hit = (iocs_n === 1'b0 && iorw_n === 1'b0 && ioaddr === ADDR_DBUF);
        end
        n_cmp++; if (!hit) begin n_fail++; $display("FAIL mid_wr_seen: got 0 want 1"); end
        rst_n = 1'b0;
        sif.tx_valid = 1'b0;
        step();
        n_cmp++; if (iocs_n !== 1'b1) begin n_fail++; $display("FAIL mid_iocs_n: got %b want 1", iocs_n); end
        n_cmp++; if (iorw_n !== 1'b1) begin n_fail++; $display("FAIL mid_iorw_n: got %b want 1", iorw_n); end
        n_cmp++; if (sif.tx_ready !== 1'b1) begin n_fail++; $display("FAIL mid_tx_ready: got %b want 1", sif.tx_ready); end
        n_cmp++; if (sif.rx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rx_valid: got %b want 0", sif.rx_valid); end
        n_cmp++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL mid_init_done: got %b want 0", init_done); end
        idx = acc_log.size();
        rst_n = 1'b1;
        t = 0;
        while (acc_log.size() < idx + 3 && t < 50) begin step(); t++; end
        n_cmp++;
        if (acc_log.size() < idx + 3) begin n_fail++; $display("FAIL mid_restart timeout: %0d accesses want %0d", acc_log.size(), idx + 3); end
        else begin
            n_cmp++; if (acc_log[idx] !== '{wr: 1'b1, addr: ADDR_DBL, data: 8'h2C}) begin n_fail++; $display("FAIL mid_restart_dbl: got %h", acc_log[idx]); end
            n_cmp++; if (acc_log[idx+1] !== '{wr: 1'b1, addr: ADDR_DBH, data: 8'h0A}) begin n_fail++; $display("FAIL mid_restart_dbh: got %h", acc_log[idx+1]); end
            n_cmp++; if (acc_log[idx+2].addr !== ADDR_SREG || acc_log[idx+2].wr !== 1'b0) begin n_fail++; $display("FAIL mid_restart_poll: got %h", acc_log[idx+2]); end
        end
    endtask

    initial begin
        sif.tx_data  = 8'h00;
        sif.tx_valid = 1'b0;
        sif.rx_ready = 1'b1;
        test_reset();
        test_tx_burst();
        test_rx_basic();
        test_rx_backpressure();
        test_round_robin();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
